// File: rtl/mem_dump_unit.sv
// mem_dump_unit: post-halt data-memory readout engine.
// A rising edge of Stop starts one pass over RAM words 0..DEPTH-1. Each word
// is read through a 1-cycle-latency port, parked in a 2-entry FIFO and
// streamed out with its address on a valid/ready interface.
`timescale 1ns/1ps
module mem_dump_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Stop,
  output logic              MemRen,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [DATA_W-1:0] DumpData,
  output logic [ADDR_W-1:0] DumpIndex,
  output logic              Busy,
  output logic              Done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // rd_addr is one bit wider than MemAddr so it can sit at DEPTH when
  // DEPTH == 2**ADDR_W without wrapping back to 0.
  localparam logic [ADDR_W:0]   RD_END   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [1:0]        state;
  logic              stop_q;
  logic              start;
  logic              run;
  logic              pop;
  logic              last_pop;
  logic [ADDR_W:0]   rd_addr;
  logic [2:0]        occ_next;

  // Read return stage: strobe issued last cycle and the address it carried.
  logic              vld_p1;
  logic [ADDR_W-1:0] idx_p1;

  // Output FIFO: entry 0 is the head presented on DumpData/DumpIndex.
  logic [1:0]        cnt;
  logic [DATA_W-1:0] e0_data;
  logic [ADDR_W-1:0] e0_idx;
  logic [DATA_W-1:0] e1_data;
  logic [ADDR_W-1:0] e1_idx;

  assign run       = (state == S_RUN);
  assign start     = (state == S_IDLE) && Stop && !stop_q;
  assign DumpValid = (cnt != 2'd0);
  assign DumpData  = e0_data;
  assign DumpIndex = e0_idx;
  assign pop       = DumpValid && DumpReady;
  assign last_pop  = run && pop && (e0_idx == LAST_IDX);
  assign Busy      = run;
  assign Done      = (state == S_FIN);

  // Words held once this cycle settles: a new strobe is only allowed when the
  // FIFO is guaranteed a free slot for its return, so at most two words are
  // ever read ahead of the sink.
  assign occ_next = {1'b0, cnt} + {2'b00, vld_p1} - {2'b00, pop};
  assign MemRen   = run && (rd_addr < RD_END) && (occ_next < 3'd2);
  assign MemAddr  = rd_addr[ADDR_W-1:0];

  // Control FSM with Stop edge detection; only IDLE reacts to a Stop edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      stop_q <= 1'b0;
    end else begin
      stop_q <= Stop;
      case (state)
        S_IDLE:  if (start)    state <= S_RUN;
        S_RUN:   if (last_pop) state <= S_FIN;
        S_FIN:   if (!Stop)    state <= S_IDLE;
        default:               state <= S_IDLE;
      endcase
    end
  end

  // Read address: restarts at 0 on each dump and advances once per strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_addr <= '0;
    end else if (start) begin
      rd_addr <= '0;
    end else if (MemRen) begin
      rd_addr <= rd_addr + 1'b1;
    end
  end

  // ---- stage p0 -> p1: strobe issued, RAM returns data next cycle ----
  // In-flight flag; cleared by reset so a pending read is discarded.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= MemRen;
    end
  end

  // Address tag that accompanies the in-flight read.
  always_ff @(posedge Clk) begin
    if (MemRen) begin
      idx_p1 <= rd_addr[ADDR_W-1:0];
    end
  end

  // ---- stage p1 -> FIFO: returned word captured with its address ----
  // FIFO occupancy and head entry; head only changes on push into an empty
  // slot or on pop, so it stays stable while the sink stalls.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt     <= 2'd0;
      e0_data <= '0;
      e0_idx  <= '0;
    end else begin
      case ({vld_p1, pop})
        2'b10: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd0) begin
            e0_data <= MemRdata;
            e0_idx  <= idx_p1;
          end
        end
        2'b01: begin
          cnt     <= cnt - 2'd1;
          e0_data <= e1_data;
          e0_idx  <= e1_idx;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0_data <= MemRdata;
            e0_idx  <= idx_p1;
          end else begin
            e0_data <= e1_data;
            e0_idx  <= e1_idx;
          end
        end
        default: ;
      endcase
    end
  end

  // Second FIFO entry; only meaningful while cnt == 2.
  always_ff @(posedge Clk) begin
    if (vld_p1 && !pop && (cnt == 2'd1)) begin
      e1_data <= MemRdata;
      e1_idx  <= idx_p1;
    end else if (vld_p1 && pop && (cnt == 2'd2)) begin
      e1_data <= MemRdata;
      e1_idx  <= idx_p1;
    end
  end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Testbench for mem_dump_unit: a RAM model feeds the DUT, and a reference
// model tracks the expected beat order, read addresses and read-ahead depth.
`timescale 1ns/1ps
module tb_mem_dump_unit;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int N  = 512;

  logic          clk;
  logic          rst_n;
  logic          stop;
  logic          ren;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [AW-1:0] idx;
  logic          busy;
  logic          done;

  logic          stop_b;
  logic          ren_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] rdata_b;
  logic          valid_b;
  logic          ready_b;
  logic [DW-1:0] data_b;
  logic [AW-1:0] idx_b;
  logic          busy_b;
  logic          done_b;

  logic [DW-1:0] ram [0:N-1];

  int checks;
  int errors;
  int exp_idx;
  int next_rd;
  int strobes;
  bit hold;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_i;

  mem_dump_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(N)) dut (
    .Clk(clk), .Reset_n(rst_n), .Stop(stop),
    .MemRen(ren), .MemAddr(addr), .MemRdata(rdata),
    .DumpValid(valid), .DumpReady(ready), .DumpData(data), .DumpIndex(idx),
    .Busy(busy), .Done(done)
  );

  mem_dump_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .Stop(stop_b),
    .MemRen(ren_b), .MemAddr(addr_b), .MemRdata(rdata_b),
    .DumpValid(valid_b), .DumpReady(ready_b), .DumpData(data_b), .DumpIndex(idx_b),
    .Busy(busy_b), .Done(done_b)
  );

  assign ready_b = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency synchronous RAM read ports
  always @(posedge clk) begin
    if (ren)   rdata   <= ram[addr];
    if (ren_b) rdata_b <= ram[addr_b];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_ren"}, ren, 1'b0);
    chkn({tag, "_addr"}, 64'(addr), 64'd0);
    chk1({tag, "_valid"}, valid, 1'b0);
    chkn({tag, "_data"}, 64'(data), 64'd0);
    chkn({tag, "_index"}, 64'(idx), 64'd0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
  endtask

  // Per-cycle reference check; called mid-cycle with inputs already settled.
  task automatic observe();
    if (hold) begin
      chk1("stall_valid", valid, 1'b1);
      chkn("stall_data", 64'(data), 64'(hold_d));
      chkn("stall_index", 64'(idx), 64'(hold_i));
    end
    if (ren) begin
      chkn("strobe_addr", 64'(addr), 64'(next_rd));
      next_rd++;
      strobes++;
    end
    if (valid && ready) begin
      chkn("beat_index", 64'(idx), 64'(exp_idx));
      chkn("beat_data", 64'(data), 64'(ram[exp_idx[8:0]]));
      exp_idx++;
      hold = 1'b0;
    end else if (valid) begin
      hold   = 1'b1;
      hold_d = data;
      hold_i = idx;
    end else begin
      hold = 1'b0;
    end
    chk1("read_ahead", (strobes - exp_idx) <= 2, 1'b1);
  endtask

  // rmode 0: ready high, 1: random ready, 2: ready low for 10 cycles.
  task automatic dump(input int rmode, input int fall_at, input int rst_at);
    int first_r;
    int first_v;
    int bubbles;
    exp_idx = 0;
    next_rd = 0;
    strobes = 0;
    hold    = 1'b0;
    first_r = -1;
    first_v = -1;
    bubbles = 0;
    stop    = 1'b1;
    for (int c = 1; c <= 4000 && exp_idx < N; c++) begin
      @(posedge clk); #1;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = (c > 10);
      endcase
      #1;
      if (c == 1) chk1("busy_after_start", busy, 1'b1);
      if (ren && first_r < 0) first_r = c;
      if (valid && first_v < 0) first_v = c;
      if (rmode == 0 && first_v > 0 && !valid) bubbles++;
      observe();
      if (rmode == 2 && c == 10) begin
        chkn("stall_strobe_count", 64'(strobes), 64'd2);
        chk1("stall_head_valid", valid, 1'b1);
        chkn("stall_head_index", 64'(idx), 64'd0);
      end
      if (exp_idx == fall_at) stop = 1'b0;
      if (exp_idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        return;
      end
    end
    chkn("latency_ren", 64'(first_r), 64'd1);
    chkn("latency_valid", 64'(first_v), 64'd3);
    if (rmode == 0) chkn("bubbles", 64'(bubbles), 64'd0);
    chkn("beats_total", 64'(exp_idx), 64'(N));
    chkn("strobes_total", 64'(strobes), 64'(N));
    @(posedge clk); #2;
    chk1("done_after_last", done, 1'b1);
    chk1("valid_after_last", valid, 1'b0);
    chk1("busy_after_last", busy, 1'b0);
    chk1("ren_after_last", ren, 1'b0);
  endtask

  task automatic hold_high();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      chk1("held_no_ren", ren, 1'b0);
      chk1("held_no_busy", busy, 1'b0);
      chk1("held_done", done, 1'b1);
    end
  endtask

  task automatic drop_stop();
    stop = 1'b0;
    @(posedge clk); #2;
    chk1("done_cleared", done, 1'b0);
    chk1("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int sb;
    int bb;
    int fv;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    stop   = 1'b0;
    stop_b = 1'b0;
    ready  = 1'b0;
    for (int j = 0; j < N; j++) ram[j[8:0]] = DW'(j * 3);

    #3;
    chk_reset_outputs("reset");
    chk1("reset_b_ren", ren_b, 1'b0);
    chk1("reset_b_done", done_b, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;

    // ramp pattern, sink always ready, then Stop held high
    dump(0, -1, -1);
    hold_high();
    drop_stop();

    // random data, random backpressure
    for (int j = 0; j < N; j++) ram[j[8:0]] = $urandom;
    dump(1, -1, -1);
    drop_stop();

    // sink stalled for the first 10 cycles
    dump(2, -1, -1);
    drop_stop();

    // async reset mid-dump with Stop still high, then a fresh dump
    dump(1, -1, 100);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dump(1, -1, -1);
    drop_stop();

    // Stop falls mid-dump: completes, Done pulses, then re-rise repeats it
    dump(0, 50, -1);
    @(posedge clk); #2;
    chk1("done_pulse_end", done, 1'b0);
    dump(0, -1, -1);
    hold_high();
    drop_stop();

    // single-word dump
    sb = 0;
    bb = 0;
    fv = -1;
    stop_b = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #2;
      if (ren_b) begin
        chkn("d1_strobe_addr", 64'(addr_b), 64'd0);
        sb++;
      end
      if (valid_b) begin
        if (fv < 0) fv = c;
        chkn("d1_index", 64'(idx_b), 64'd0);
        chkn("d1_data", 64'(data_b), 64'(ram[0]));
        bb++;
      end
    end
    chkn("d1_strobes", 64'(sb), 64'd1);
    chkn("d1_beats", 64'(bb), 64'd1);
    chkn("d1_latency", 64'(fv), 64'd3);
    chk1("d1_done", done_b, 1'b1);
    chk1("d1_busy", busy_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
